dmem_responder: RTL and testbench

Data-memory responder for the pipelined processor's data-memory port. It services the MEM-stage load/store requests: combinational reads and single-cycle synchronous writes. It also runs a dump sequencer that streams the full memory contents, word by word, over a valid/ready channel to the testbench or debug logger when `dump` rises. It sits at the top level, between the datapath's `DM_*` outputs and the debug sink.

---
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// Combinational reads, single-cycle synchronous writes, and a dump
// sequencer that streams every memory word over a valid/ready channel
// after a rising edge on `dump`.
// Optional feature: define DMEM_DUMP_SKIP_ZERO_EN to skip zero-valued words
// during a dump (they advance one per cycle without a transfer).
module dmem_responder #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memWrite,
  input  logic          memRead,
  input  logic [AW-1:0] address,
  input  logic [N-1:0]  writeData,
  output logic [N-1:0]  readData,
  input  logic          dump,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [N-1:0]  dump_data,
  output logic          dump_done
);

  localparam int              DEPTH    = 1 << AW;
  localparam logic [AW-1:0]   LAST_IDX = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Storage and sequencer state
  logic [N-1:0]  r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_dump_q;

  // Combinational helpers
  logic          w_start;
  logic          w_in_dump;
  logic          w_last;
  logic          w_valid;
  logic          w_advance;
  logic [N-1:0]  w_idx_word;

  // A held-high dump never retriggers: only the 0->1 transition starts one.
  assign w_start    = dump & ~r_dump_q;
  assign w_in_dump  = (r_state == S_DUMP);
  assign w_last     = (r_idx == LAST_IDX);
  // Live contents of the word under the dump pointer; a write to it is seen
  // here only after the edge, so a handoff in the write cycle carries the
  // old value.
  assign w_idx_word = r_mem[r_idx];

`ifdef DMEM_DUMP_SKIP_ZERO_EN
  logic w_word_zero;
  assign w_word_zero = (w_idx_word == {N{1'b0}});
  // Zero words are not offered; the pointer walks past them unconditionally.
  assign w_valid     = w_in_dump & ~w_word_zero;
  assign w_advance   = w_in_dump & (w_word_zero | dump_ready);
`else
  assign w_valid     = w_in_dump;
  assign w_advance   = w_in_dump & dump_ready;
`endif

  assign readData   = memRead ? r_mem[address] : {N{1'b0}};
  assign dump_valid = w_valid;
  assign dump_addr  = w_in_dump ? r_idx : {AW{1'b0}};
  assign dump_data  = w_in_dump ? w_idx_word : {N{1'b0}};
  assign dump_done  = (r_state == S_DONE);

  // Memory array: cleared by reset, written on any store regardless of dump state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {N{1'b0}};
      end
    end else if (memWrite) begin
      r_mem[address] <= writeData;
    end
  end

  // Dump sequencer: edge detect, IDLE -> DUMP -> DONE -> IDLE walk over all words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= {AW{1'b0}};
      r_dump_q <= 1'b0;
    end else begin
      r_dump_q <= dump;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_DUMP;
            r_idx   <= {AW{1'b0}};
          end
        end
        S_DUMP: begin
          // Terminal check precedes the increment so the pointer never wraps.
          if (w_advance) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= {AW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a behavioural memory/dump model
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_dmem_responder;

  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          memWrite;
  logic          memRead;
  logic [AW-1:0] address;
  logic [N-1:0]  writeData;
  logic [N-1:0]  readData;
  logic          dump;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_done;

  always #5 clk = ~clk;

  dmem_responder #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .dump       (dump),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem [DEPTH];
  bit          m_dumping = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_prev    = 1'b0;
  int          m_pos     = 0;
  bit          m_adv;
  bit          chk_en    = 1'b0;

  // A word is offered while walking, unless skip-zero mode hides zero words.
  function automatic bit m_valid();
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    return m_dumping && (m_mem[m_pos] != 64'd0);
`else
    return m_dumping;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
      m_dumping = 1'b0;
      m_done    = 1'b0;
      m_prev    = 1'b0;
      m_pos     = 0;
    end else begin
      m_adv = m_dumping && (m_valid() ? dump_ready : 1'b1);
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_dumping) begin
        if (m_adv) begin
          if (m_pos == DEPTH - 1) begin
            m_dumping = 1'b0;
            m_done    = 1'b1;
          end else begin
            m_pos++;
          end
        end
      end else if (dump && !m_prev) begin
        m_dumping = 1'b1;
        m_pos     = 0;
      end
      if (memWrite) m_mem[address] = writeData;
      m_prev = dump;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("readData", readData, memRead ? m_mem[address] : 64'd0);
      check("dump_valid", {63'd0, dump_valid}, {63'd0, m_valid()});
      check("dump_done", {63'd0, dump_done}, {63'd0, m_done});
      if (m_valid()) begin
        check("dump_addr", {58'd0, dump_addr}, 64'(m_pos));
        check("dump_data", dump_data, m_mem[m_pos]);
      end
    end
  end

  // Transfer monitor feeding the literal scenario checks.
  logic [AW-1:0] log_addr [$];
  logic [63:0]   log_data [$];
  int            done_cnt  = 0;
  int            valid_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (dump_valid && dump_ready) begin
        log_addr.push_back(dump_addr);
        log_data.push_back(dump_data);
      end
      if (dump_valid) valid_cnt++;
      if (dump_done)  done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memWrite = 1'b0; memRead = 1'b0; address = 6'd0;
    writeData = 64'd0; dump = 1'b0; dump_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", {63'd0, dump_valid}, 64'd0);
    check("rst_addr", {58'd0, dump_addr}, 64'd0);
    check("rst_data", dump_data, 64'd0);
    check("rst_done", {63'd0, dump_done}, 64'd0);

    // Reads after reset: everything zero.
    memRead = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      address = 6'(a);
      tick();
    end
    check("rd_zero_63", readData, 64'd0);

    // Store then read; memRead low masks the output.
    memRead = 1'b0; memWrite = 1'b1; address = 6'd5; writeData = 64'hDEADBEEF_00000001;
    tick();
    memWrite = 1'b0;
    #1 check("rd_masked", readData, 64'd0);
    memRead = 1'b1;
    #1 check("rd_addr5", readData, 64'hDEADBEEF_00000001);
    memWrite = 1'b1; address = 6'd63; writeData = 64'h01234567_89ABCDEF;
    tick();
    memWrite = 1'b0;
    #1 check("rd_addr63", readData, 64'h01234567_89ABCDEF);
    address = 6'd0;
    #1 check("rd_addr0", readData, 64'd0);

    // Fill mem[i] = i+1, then full dump with dump held high for 100 cycles.
    memWrite = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      address = 6'(i); writeData = 64'(i + 1);
      tick();
    end
    memWrite = 1'b0;
    clear_log();
    dump_ready = 1'b1; dump = 1'b1;
    repeat (100) tick();
    dump = 1'b0;
    tick();
    check("full_xfers", 64'(log_addr.size()), 64'd64);
    check("full_valid_cycles", 64'(valid_cnt), 64'd64);
    check("full_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < DEPTH && i < log_addr.size(); i++) begin
      check("full_addr", {58'd0, log_addr[i]}, 64'(i));
      check("full_data", log_data[i], 64'(i + 1));
    end

    // Random back-pressure with a store to the handoff word.
    clear_log();
    dump_ready = 1'b0; dump = 1'b1;
    tick();
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      dump_ready = 1'($urandom_range(0, 1));
      if (dump_ready && m_dumping) begin
        memWrite = 1'b1; address = 6'(m_pos); writeData = 64'hAA;
      end else begin
        memWrite = 1'b0;
      end
      tick();
    end
    memWrite = 1'b0; dump = 1'b0; dump_ready = 1'b0;
    tick();
    check("bp_xfers", 64'(log_addr.size()), 64'd64);
    check("bp_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < DEPTH && i < log_addr.size(); i++) begin
      check("bp_addr", {58'd0, log_addr[i]}, 64'(i));
      check("bp_old_data", log_data[i], 64'(i + 1));
    end
    memRead = 1'b1; address = 6'd31;
    #1 check("bp_new_31", readData, 64'hAA);

    // Reset in the middle of a dump at idx 20.
    clear_log();
    dump_ready = 1'b1; dump = 1'b1;
    tick();
    repeat (20) tick();
    check("mid_addr20", {58'd0, dump_addr}, 64'd20);
    dump_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; dump = 1'b0;
    check("mid_valid", {63'd0, dump_valid}, 64'd0);
    repeat (5) tick();
    check("mid_no_done", 64'(done_cnt), 64'd0);
    check("mid_xfers", 64'(log_addr.size()), 64'd20);
    address = 6'd20;
    #1 check("mid_mem20", readData, 64'd0);
    address = 6'd5;
    #1 check("mid_mem5", readData, 64'd0);

    // Sparse memory: nonzero only at 3 and 63.
    memWrite = 1'b1; address = 6'd3; writeData = 64'h33;
    tick();
    address = 6'd63; writeData = 64'h6363;
    tick();
    memWrite = 1'b0;
    clear_log();
    dump_ready = 1'b1; dump = 1'b1;
    tick();
    dump = 1'b0;
    repeat (70) tick();
    check("sparse_done_cnt", 64'(done_cnt), 64'd1);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    check("sparse_xfers", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      check("sparse_addr0", {58'd0, log_addr[0]}, 64'd3);
      check("sparse_data0", log_data[0], 64'h33);
      check("sparse_addr1", {58'd0, log_addr[1]}, 64'd63);
      check("sparse_data1", log_data[1], 64'h6363);
    end
`else
    check("sparse_xfers", 64'(log_addr.size()), 64'd64);
    if (log_addr.size() == 64) begin
      check("sparse_data3", log_data[3], 64'h33);
      check("sparse_data4", log_data[4], 64'd0);
      check("sparse_data63", log_data[63], 64'h6363);
    end
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
